// File: rtl/vga_pkg.sv
// Shared pattern codes, default 640x480@60 timing and the raw timing bundle.
// Constants only; no logic.
package vga_pkg;

  localparam logic [2:0] PAT_BLACK  = 3'd0;
  localparam logic [2:0] PAT_RED    = 3'd1;
  localparam logic [2:0] PAT_GREEN  = 3'd2;
  localparam logic [2:0] PAT_BLUE   = 3'd3;
  localparam logic [2:0] PAT_WHITE  = 3'd4;
  localparam logic [2:0] PAT_CHECK  = 3'd5;
  localparam logic [2:0] PAT_BARS   = 3'd6;
  localparam logic [2:0] PAT_MOVING = 3'd7;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int MOVING_BAR_W = 16;

  // Decoded timing for the current counter position, before the output register.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame_start;
  } vga_ctl_t;

  // Colour-bar width; never zero so tiny test geometries still elaborate.
  function automatic int bar_width(input int h_active);
    return (h_active / 8 < 1) ? 1 : h_active / 8;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Column/row raster counters with combinational sync/de/frame_start decode.
// Decode is zero-latency from the counter flops; free-running, no backpressure.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW       = $clog2(H_TOTAL),
  localparam int  VW       = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [HW-1:0] o_col,
  output logic [VW-1:0] o_row,
  output vga_ctl_t      o_ctl,
  output logic          o_last_col,
  output logic          o_last_px
);

  logic [HW-1:0] col_q, col_d;
  logic [VW-1:0] row_q, row_d;
  logic [31:0]   col_w, row_w;
  logic          last_col, last_row;
  logic          hs_act, vs_act;

  always_comb begin
    col_w    = 32'(col_q);
    row_w    = 32'(row_q);
    last_col = (col_w == 32'(H_TOTAL - 1));
    last_row = (row_w == 32'(V_TOTAL - 1));
    col_d    = col_q + 1'b1;
    row_d    = row_q;
    if (last_col) begin
      col_d = '0;
      row_d = last_row ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Compare in 32 bits so the sync end bound can never overflow the counter width.
  always_comb begin
    hs_act = (col_w >= 32'(H_ACTIVE + H_FP)) && (col_w <= 32'(H_ACTIVE + H_FP + H_SYNC - 1));
    vs_act = (row_w >= 32'(V_ACTIVE + V_FP)) && (row_w <= 32'(V_ACTIVE + V_FP + V_SYNC - 1));
    o_ctl             = '0;
    o_ctl.hsync       = hs_act ? SYNC_POL : ~SYNC_POL;
    o_ctl.vsync       = vs_act ? SYNC_POL : ~SYNC_POL;
    o_ctl.de          = (col_w < 32'(H_ACTIVE)) && (row_w < 32'(V_ACTIVE));
    o_ctl.frame_start = (col_w == 32'd0) && (row_w == 32'd0);
  end

  assign o_col      = col_q;
  assign o_row      = row_q;
  assign o_last_col = last_col;
  assign o_last_px  = last_col && last_row;

endmodule

// File: rtl/vga_pattern_engine.sv
// VGA timing plus 8 test patterns; pattern latched at frame start, bar position steps per frame.
// All outputs registered one clock after the counter position; free-running, no backpressure.
module vga_pattern_engine
  import vga_pkg::*;
#(
  parameter int   VIDEO_WIDTH = 3,
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   CHECK_LOG2  = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [2:0]             i_pattern,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_de,
  output logic                   o_frame_start,
  output logic [VIDEO_WIDTH-1:0] o_red,
  output logic [VIDEO_WIDTH-1:0] o_green,
  output logic [VIDEO_WIDTH-1:0] o_blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = bar_width(H_ACTIVE);
  localparam int BCW     = $clog2(BAR_W + 1);

  localparam logic [VIDEO_WIDTH-1:0] FULL = '1;
  localparam logic [VIDEO_WIDTH-1:0] NONE = '0;

  logic [HW-1:0] col;
  logic [VW-1:0] row;
  vga_ctl_t      ctl;
  logic          last_col, last_px;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_col      (col),
    .o_row      (row),
    .o_ctl      (ctl),
    .o_last_col (last_col),
    .o_last_px  (last_px)
  );

  logic [2:0]             pat_q, pat_d;
  logic [BCW-1:0]         bar_cnt_q, bar_cnt_d;
  logic [2:0]             bar_idx_q, bar_idx_d;
  logic [HW-1:0]          bar_pos_q, bar_pos_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   de_q, de_d;
  logic                   frame_start_q, frame_start_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] green_q, green_d;
  logic [VIDEO_WIDTH-1:0] blue_q, blue_d;
  logic [31:0]            col_w, row_w, pos_w;
  logic                   check_on, moving_on;

  // pat_d doubles as the effective pattern so pixel (0,0) already uses the new selection.
  always_comb begin
    pat_d = ctl.frame_start ? i_pattern : pat_q;
  end

  // bar_idx tracks col / BAR_W incrementally; saturates past the last bar (blanked anyway).
  always_comb begin
    bar_cnt_d = bar_cnt_q + 1'b1;
    bar_idx_d = bar_idx_q;
    if (last_col) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (32'(bar_cnt_q) == 32'(BAR_W - 1)) begin
      bar_cnt_d = '0;
      bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 1'b1;
    end
  end

  // Stepping on the last pixel means each new frame starts with its advanced position.
  always_comb begin
    bar_pos_d = bar_pos_q;
    if (last_px) begin
      bar_pos_d = (32'(bar_pos_q) + 32'd1 >= 32'(H_ACTIVE)) ? '0 : bar_pos_q + 1'b1;
    end
  end

  always_comb begin
    col_w     = 32'(col);
    row_w     = 32'(row);
    pos_w     = 32'(bar_pos_q);
    check_on  = ((col_w >> CHECK_LOG2) & 32'd1) != ((row_w >> CHECK_LOG2) & 32'd1);
    moving_on = (col_w >= pos_w) && (col_w < pos_w + 32'(MOVING_BAR_W)) &&
                (col_w < 32'(H_ACTIVE));
  end

  always_comb begin
    red_d   = NONE;
    green_d = NONE;
    blue_d  = NONE;
    if (ctl.de) begin
      case (pat_d)
        PAT_RED:   red_d   = FULL;
        PAT_GREEN: green_d = FULL;
        PAT_BLUE:  blue_d  = FULL;
        PAT_WHITE: begin
          red_d   = FULL;
          green_d = FULL;
          blue_d  = FULL;
        end
        PAT_CHECK: begin
          red_d   = check_on ? FULL : NONE;
          green_d = check_on ? FULL : NONE;
          blue_d  = check_on ? FULL : NONE;
        end
        PAT_BARS: begin
          red_d   = {VIDEO_WIDTH{bar_idx_q[2]}};
          green_d = {VIDEO_WIDTH{bar_idx_q[1]}};
          blue_d  = {VIDEO_WIDTH{bar_idx_q[0]}};
        end
        PAT_MOVING: begin
          red_d   = moving_on ? FULL : NONE;
          green_d = moving_on ? FULL : NONE;
          blue_d  = FULL;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hsync_d       = ctl.hsync;
    vsync_d       = ctl.vsync;
    de_d          = ctl.de;
    frame_start_d = ctl.frame_start;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pat_q         <= PAT_BLACK;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      bar_pos_q     <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      pat_q         <= pat_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      bar_pos_q     <= bar_pos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_de          = de_q;
  assign o_frame_start = frame_start_q;
  assign o_red         = red_q;
  assign o_green       = green_q;
  assign o_blue        = blue_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Runs a default 640x480 instance and a tiny SYNC_POL=1 instance against a raster-arithmetic model.
module tb_vga_pattern_engine;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } px_t;

  localparam int DFR = 800 * 525;
  localparam int SHA = 16, SHFP = 2, SHS = 3, SHBP = 3;
  localparam int SVA = 8,  SVFP = 1, SVS = 2, SVBP = 2;
  localparam int SHT = SHA + SHFP + SHS + SHBP;
  localparam int SVT = SVA + SVFP + SVS + SVBP;
  localparam int SFR = SHT * SVT;
  localparam int SCHK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d_n, rst_s_n;
  logic [2:0] pat_d, pat_s;
  logic       hs_d, vs_d, de_d, fs_d, hs_s, vs_s, de_s, fs_s;
  logic [2:0] r_d, g_d, b_d, r_s, g_s, b_s;

  vga_pattern_engine u_dut_d (
    .i_clk(clk), .i_rst_n(rst_d_n), .i_pattern(pat_d),
    .o_hsync(hs_d), .o_vsync(vs_d), .o_de(de_d), .o_frame_start(fs_d),
    .o_red(r_d), .o_green(g_d), .o_blue(b_d)
  );

  vga_pattern_engine #(
    .VIDEO_WIDTH(3), .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP),
    .SYNC_POL(1'b1), .CHECK_LOG2(SCHK)
  ) u_dut_s (
    .i_clk(clk), .i_rst_n(rst_s_n), .i_pattern(pat_s),
    .o_hsync(hs_s), .o_vsync(vs_s), .o_de(de_s), .o_frame_start(fs_s),
    .o_red(r_s), .o_green(g_s), .o_blue(b_s)
  );

  int checks = 0;
  int failures = 0;

  // Expected pixel t clocks after reset release, from raster arithmetic only.
  function automatic px_t model_px(input int t, input int pat, input int ha, input int hfp,
                                   input int hsw, input int hbp, input int va, input int vfp,
                                   input int vsw, input int vbp, input logic pol, input int chk);
    int  ht, vt, col, row, frame, k, bp;
    px_t p;
    ht    = ha + hfp + hsw + hbp;
    vt    = va + vfp + vsw + vbp;
    col   = t % ht;
    row   = (t / ht) % vt;
    frame = t / (ht * vt);
    p     = '0;
    p.hs  = (col >= ha + hfp && col < ha + hfp + hsw) ? pol : ~pol;
    p.vs  = (row >= va + vfp && row < va + vfp + vsw) ? pol : ~pol;
    p.de  = (col < ha) && (row < va);
    p.fs  = (col == 0) && (row == 0);
    if (p.de) begin
      case (pat)
        1: p.r = 3'd7;
        2: p.g = 3'd7;
        3: p.b = 3'd7;
        4: begin p.r = 3'd7; p.g = 3'd7; p.b = 3'd7; end
        5: if ((((col >> chk) ^ (row >> chk)) & 1) == 1) begin
             p.r = 3'd7; p.g = 3'd7; p.b = 3'd7;
           end
        6: begin
          k   = col / ((ha / 8 < 1) ? 1 : ha / 8);
          p.r = ((k >> 2) & 1) == 1 ? 3'd7 : 3'd0;
          p.g = ((k >> 1) & 1) == 1 ? 3'd7 : 3'd0;
          p.b = (k & 1) == 1 ? 3'd7 : 3'd0;
        end
        7: begin
          bp  = frame % ha;
          p.b = 3'd7;
          if (col >= bp && col < bp + 16) begin p.r = 3'd7; p.g = 3'd7; end
        end
        default: ;
      endcase
    end
    return p;
  endfunction

  function automatic px_t reset_px(input logic pol);
    px_t p;
    p    = '0;
    p.hs = ~pol;
    p.vs = ~pol;
    return p;
  endfunction

  // Model state: clocks since release and the pattern latched at the last frame start.
  int cnt_d = 0, cnt_s = 0, mpat_d = 0, mpat_s = 0;
  bit started = 0;
  int nprint = 0;

  always @(posedge clk) begin
    started = 1;
    if (!rst_d_n) begin cnt_d = 0; mpat_d = 0; end
    else begin
      if (cnt_d % DFR == 0) mpat_d = int'(pat_d);
      cnt_d++;
    end
    if (!rst_s_n) begin cnt_s = 0; mpat_s = 0; end
    else begin
      if (cnt_s % SFR == 0) mpat_s = int'(pat_s);
      cnt_s++;
    end
  end

  always @(negedge clk) begin
    px_t exp_d, exp_s, act_d, act_s;
    if (started) begin
      exp_d = (cnt_d == 0) ? reset_px(1'b0) :
              model_px(cnt_d - 1, mpat_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 5);
      exp_s = (cnt_s == 0) ? reset_px(1'b1) :
              model_px(cnt_s - 1, mpat_s, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP, 1'b1, SCHK);
      act_d = {hs_d, vs_d, de_d, fs_d, r_d, g_d, b_d};
      act_s = {hs_s, vs_s, de_s, fs_s, r_s, g_s, b_s};
      checks += 2;
      if (act_d !== exp_d) begin
        failures++;
        if (nprint++ < 30) $display("FAIL cmp_default t=%0d got=%b expected=%b", cnt_d - 1, act_d, exp_d);
      end
      if (act_s !== exp_s) begin
        failures++;
        if (nprint++ < 30) $display("FAIL cmp_small t=%0d got=%b expected=%b", cnt_s - 1, act_s, exp_s);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_s(input int tgt);
    int n;
    n = 0;
    while ((cnt_s - 1 != tgt) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      failures++;
      $display("FAIL wait_small timeout target=%0d got_t=%0d", tgt, cnt_s - 1);
    end
  endtask

  function automatic int rgb_s();
    return {23'd0, r_s, g_s, b_s};
  endfunction

  function automatic int rgb_d();
    return {23'd0, r_d, g_d, b_d};
  endfunction

  initial begin
    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    pat_d   = 3'd6;
    pat_s   = 3'd7;
    fork
      begin : default_branch
        int hs_cnt, de_cnt;
        hs_cnt = 0;
        de_cnt = 0;
        repeat (3) @(negedge clk);
        chk("d_reset_hsync", int'(hs_d), 1);
        chk("d_reset_de", int'(de_d), 0);
        #1 rst_d_n = 1'b1;
        for (int i = 0; i < 2400; i++) begin
          @(negedge clk);
          if (!hs_d) hs_cnt++;
          if (de_d) de_cnt++;
          case (cnt_d - 1)
            0: begin chk("d_first_fs", int'(fs_d), 1); chk("d_bar0", rgb_d(), 'o000); end
            80:  chk("d_bar1", rgb_d(), 'o007);
            480: chk("d_bar6", rgb_d(), 'o770);
            560: chk("d_bar7", rgb_d(), 'o777);
            650: chk("d_blank_rgb", rgb_d(), 0);
            default: ;
          endcase
        end
        chk("d_hsync_clks_3lines", hs_cnt, 3 * 96);
        chk("d_de_clks_3lines", de_cnt, 3 * 640);
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(200, 1500)) @(negedge clk);
          #1 rst_d_n = 1'b0;
          pat_d = 3'($urandom_range(0, 7));
          repeat ($urandom_range(1, 3)) @(negedge clk);
          #1 rst_d_n = 1'b1;
        end
        repeat (900) @(negedge clk);
      end
      begin : small_branch
        repeat (3) @(negedge clk);
        chk("s_reset_hsync", int'(hs_s), 0);
        #1 rst_s_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
          if (f > 0) begin wait_s(f * SFR + f - 1); chk("s_mov_before", rgb_s(), 'o007); end
          wait_s(f * SFR + f);
          chk("s_mov_start", rgb_s(), 'o777);
        end
        wait_s(3 * SFR + 17); chk("s_hs_col17", int'(hs_s), 0);
        wait_s(3 * SFR + 18); chk("s_hs_col18", int'(hs_s), 1);
        wait_s(3 * SFR + 20); chk("s_hs_col20", int'(hs_s), 1);
        wait_s(3 * SFR + 21); chk("s_hs_col21", int'(hs_s), 0);
        wait_s(4 * SFR - 1);  chk("s_fs_before", int'(fs_s), 0);
        wait_s(4 * SFR);      chk("s_fs_period", int'(fs_s), 1);
        wait_s(15 * SFR + 14); chk("s_mov15_col14", rgb_s(), 'o007);
        wait_s(15 * SFR + 15); chk("s_mov15_col15", rgb_s(), 'o777);
        wait_s(16 * SFR);      chk("s_mov_wrap_col0", rgb_s(), 'o777);
        #1 pat_s = 3'd1;
        wait_s(17 * SFR + 4 * SHT + 3);
        #1 pat_s = 3'd3;
        wait_s(17 * SFR + 5 * SHT + 2);  chk("s_no_tear_red", rgb_s(), 'o700);
        wait_s(17 * SFR + 7 * SHT + 15); chk("s_red_last_px", rgb_s(), 'o700);
        wait_s(18 * SFR);
        chk("s_blue_next_frame", rgb_s(), 'o007);
        chk("s_blue_fs", int'(fs_s), 1);
        wait_s(18 * SFR + 5 * SHT + 7);
        #1 rst_s_n = 1'b0;
        pat_s = 3'd5;
        @(negedge clk);
        chk("s_midreset_hs", int'(hs_s), 0);
        chk("s_midreset_de", int'(de_s), 0);
        chk("s_midreset_rgb", rgb_s(), 0);
        repeat (2) @(negedge clk);
        #1 rst_s_n = 1'b1;
        @(negedge clk);
        chk("s_restart_fs", int'(fs_s), 1);
        chk("s_restart_de", int'(de_s), 1);
        wait_s(4); chk("s_check_col4", rgb_s(), 'o777);
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(1, 200)) @(negedge clk);
          #1 pat_s = 3'($urandom_range(0, 7));
          if ($urandom_range(0, 9) == 0) begin
            rst_s_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1 rst_s_n = 1'b1;
          end
        end
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
